token_precision_analyzer_stream: RTL and testbench

Streaming, parametrised successor to the token precision analyzer in the mixed-precision attention path. It accepts an attention tensor of shape (L, N, L) one row of L scores per beat over a valid/ready handshake. It accumulates each key-token column with saturation, then classifies every column into a 4-bit precision code (INT4/INT8/FP16) against runtime-programmable thresholds. Results are held under an output valid/ready handshake for the downstream quantiser.

---
 rtl/token_precision_analyzer_stream.sv | 163 ++++++++++++++++
 tb/tb_token_precision_analyzer_stream.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_precision_analyzer_stream.sv
// Purpose: accumulate L key-token columns over L*N row beats with saturation, then classify each column as INT4/INT8/FP16.
// Latency: start in cycle T, last back-to-back beat at T+L*N, one CLASSIFY cycle, out_valid/done at T+L*N+2.
// Backpressure: a_ready is high only in ACCUM; the result is held in OUT until out_valid && out_ready.
module token_precision_analyzer_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(L * N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ACC_WIDTH-1:0]    thr_lo,
  input  logic [ACC_WIDTH-1:0]    thr_hi,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [DATA_WIDTH*L-1:0] a_data,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*L-1:0]          token_precision,
  output logic [L-1:0]            col_sat
);

  localparam int ROWS  = L * N;
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SUM_W = ACC_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    CLASSIFY = 2'd2,
    OUT      = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] acc [L];
  logic [ACC_WIDTH-1:0] thr_lo_q;
  logic [ACC_WIDTH-1:0] thr_hi_q;
  logic [CNT_W-1:0]     row_cnt;
  logic                 done_q;
  logic                 start_acc;
  logic                 beat;
  logic [SUM_W-1:0]     sum [L];
  logic [3:0]           code [L];

  // State register; reset aborts any analysis in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs, all derived from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    a_ready   = 1'b0;
    out_valid = 1'b0;
    start_acc = 1'b0;
    beat      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        a_ready = 1'b1;
        if (a_valid) begin
          beat = 1'b1;
          if (row_cnt == LAST_ROW) begin
            state_nxt = CLASSIFY;
          end
        end
      end
      CLASSIFY: begin
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Per-column widened sum (carry bit flags overflow) and ordered threshold compare.
  always_comb begin
    for (int c = 0; c < L; c++) begin
      sum[c] = {1'b0, acc[c]} + SUM_W'(a_data[c*DATA_WIDTH +: DATA_WIDTH]);
      if (acc[c] < thr_lo_q) begin
        code[c] = 4'd0;
      end else if (acc[c] < thr_hi_q) begin
        code[c] = 4'd1;
      end else begin
        code[c] = 4'd2;
      end
    end
  end

  // Accumulators, row counter, saturation flags and threshold latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < L; c++) begin
        acc[c] <= '0;
      end
      row_cnt  <= '0;
      col_sat  <= '0;
      thr_lo_q <= '0;
      thr_hi_q <= '0;
    end else if (start_acc) begin
      for (int c = 0; c < L; c++) begin
        acc[c] <= '0;
      end
      row_cnt  <= '0;
      col_sat  <= '0;
      thr_lo_q <= thr_lo;
      thr_hi_q <= thr_hi;
    end else if (beat) begin
      row_cnt <= row_cnt + CNT_W'(1);
      for (int c = 0; c < L; c++) begin
        if (sum[c][ACC_WIDTH]) begin
          acc[c]     <= '1;
          col_sat[c] <= 1'b1;
        end else begin
          acc[c] <= sum[c][ACC_WIDTH-1:0];
        end
      end
    end
  end

  // Codes are captured in CLASSIFY and held until the next analysis classifies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      token_precision <= '0;
    end else if (state == CLASSIFY) begin
      for (int c = 0; c < L; c++) begin
        token_precision[4*c +: 4] <= code[c];
      end
    end
  end

  // done is a single pulse marking the first OUT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == CLASSIFY);
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_token_precision_analyzer_stream.sv
// Purpose: directed scoreboard bench for token_precision_analyzer_stream at L=4, N=2, ACC_WIDTH=16.
// Latency: expected results queued at start; monitor compares on every out_valid cycle.
// Backpressure: exercises a_valid bubbles, out_ready stalls and ready-before-valid retirement.
module tb_token_precision_analyzer_stream;

  localparam int DW   = 16;
  localparam int LL   = 4;
  localparam int NN   = 2;
  localparam int AW   = 16;
  localparam int ROWS = LL * NN;

  typedef struct packed {
    logic [4*LL-1:0] tp;
    logic [LL-1:0]   sat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   thr_lo = '0;
  logic [AW-1:0]   thr_hi = '0;
  logic            a_valid = 1'b0;
  logic            a_ready;
  logic [DW*LL-1:0] a_data = '0;
  logic            busy;
  logic            done;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [4*LL-1:0] token_precision;
  logic [LL-1:0]   col_sat;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          lat_exp = 0;
  int          done_cnt = 0;
  logic [15:0] rows [ROWS][LL];

  token_precision_analyzer_stream #(
    .DATA_WIDTH(DW),
    .L(LL),
    .N(NN),
    .ACC_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .thr_lo(thr_lo),
    .thr_hi(thr_hi),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_data(a_data),
    .busy(busy),
    .done(done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .token_precision(token_precision),
    .col_sat(col_sat)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*LL-1:0] pack(input int r);
    logic [DW*LL-1:0] d;
    d = '0;
    for (int c = 0; c < LL; c++) d[c*DW +: DW] = rows[r][c];
    return d;
  endfunction

  task automatic set_rows(input logic [15:0] c0, input logic [15:0] c1,
                          input logic [15:0] c2, input logic [15:0] c3);
    for (int r = 0; r < ROWS; r++) begin
      rows[r][0] = c0;
      rows[r][1] = c1;
      rows[r][2] = c2;
      rows[r][3] = c3;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_token_precision"}, token_precision, 0);
    check({tag, "_col_sat"}, col_sat, 0);
  endtask

  // Monitor: compares the held result every OUT cycle, pops on retirement.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (lat_exp != 0) check("done_latency", cyc - start_cyc, lat_exp);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("token_precision", token_precision, exp_q[0].tp);
          check("col_sat", col_sat, exp_q[0].sat);
          if (out_ready) begin
            check("done_pulses", done_cnt, 1);
            done_cnt = 0;
            exp_q.delete(0);
          end
        end
      end
    end
  end

  // One analysis: start, feed ROWS beats, optionally stall the output or abort by reset.
  task automatic run(input logic [15:0] lo, input logic [15:0] hi, input bit bubbles,
                     input int stall, input int abort_after, input bit poke,
                     input logic [15:0] exp_tp, input logic [3:0] exp_sat);
    int r;
    int guard;
    exp_t e;
    start     = 1'b1;
    thr_lo    = lo;
    thr_hi    = hi;
    out_ready = (stall == 0);
    start_cyc = cyc;
    lat_exp   = bubbles ? 0 : ROWS + 2;
    if (abort_after < 0) begin
      e.tp  = exp_tp;
      e.sat = exp_sat;
      exp_q.push_back(e);
    end
    step();
    start  = 1'b0;
    thr_lo = ~lo;
    thr_hi = ~hi;
    r = 0;
    guard = 0;
    while (r < ROWS && guard < 200) begin
      guard++;
      if (bubbles && $urandom_range(0, 1) == 0) begin
        a_valid = 1'b0;
      end else begin
        a_valid = 1'b1;
        a_data  = pack(r);
        if (a_ready) r++;
      end
      if (poke && r == 3) begin
        start  = 1'b1;
        thr_lo = '0;
      end else begin
        start  = 1'b0;
      end
      step();
      if (r == abort_after) begin
        a_valid = 1'b0;
        start   = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        step();
        step();
        rst = 1'b0;
        step();
        return;
      end
    end
    a_valid = 1'b0;
    start   = 1'b0;
    check("beats_accepted", r, ROWS);
    if (stall > 0) begin
      guard = 0;
      while (!out_valid && guard < 50) begin
        step();
        guard++;
      end
      check("out_valid_rise", out_valid, 1);
      repeat (stall) step();
      out_ready = 1'b1;
    end
    guard = 0;
    while (busy && guard < 50) begin
      step();
      guard++;
    end
    check("retired_to_idle", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #3;
    check_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // a_valid in IDLE must not be accepted nor start anything.
    a_valid = 1'b1;
    repeat (3) begin
      step();
      check("a_ready_idle", a_ready, 0);
      check("busy_idle", busy, 0);
    end
    a_valid = 1'b0;
    step();

    // Column sums 8,160,240,400 against 100/200.
    set_rows(16'd1, 16'd20, 16'd30, 16'd50);
    run(16'd100, 16'd200, 1'b0, 0, -1, 1'b0, 16'h2210, 4'h0);

    // Boundary sums 100,200,99,0.
    set_rows(16'd0, 16'd0, 16'd0, 16'd0);
    rows[0][0] = 16'd100;
    rows[0][1] = 16'd200;
    rows[0][2] = 16'd99;
    run(16'd100, 16'd200, 1'b0, 0, -1, 1'b0, 16'h0021, 4'h0);

    // Every column saturates.
    set_rows(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run(16'd100, 16'd200, 1'b0, 0, -1, 1'b0, 16'h2222, 4'hF);

    // Random input bubbles and a 5-cycle output stall: same result as the clean run.
    set_rows(16'd1, 16'd20, 16'd30, 16'd50);
    run(16'd100, 16'd200, 1'b1, 5, -1, 1'b0, 16'h2210, 4'h0);

    // start and thr_lo=0 mid-ACCUM are ignored.
    run(16'd100, 16'd200, 1'b0, 0, -1, 1'b1, 16'h2210, 4'h0);

    // Inverted thresholds: no column may get code 1.
    run(16'd300, 16'd150, 1'b0, 0, -1, 1'b0, 16'h2000, 4'h0);

    // Saturating partial run aborted by reset after 3 rows.
    set_rows(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run(16'd100, 16'd200, 1'b0, 0, 3, 1'b0, 16'h0000, 4'h0);

    // Fresh run after the abort sees no stale sums.
    set_rows(16'd1, 16'd20, 16'd30, 16'd50);
    run(16'd100, 16'd200, 1'b0, 0, -1, 1'b0, 16'h2210, 4'h0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop if the bench ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
